float_add_scheduler: RTL
========================

# float_add_scheduler

Shares a single combinational `float_add` unit (8-bit float: exponent [7:5], mantissa [4:0]) between two requesters. Each requester has a valid/ready operand port and a valid/ready result port. The block grants requesters round-robin, latches the winning operand pair, and lets the adder settle for one cycle. It then registers the sum and holds it on the winner's result port until that requester accepts it. It sits between the lab's operand sources (switch/sequence logic) and the shared adder datapath.

## Interface
- `FLOAT_W`, default 8: float width; fixed by the adder, not meant to be overridden.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `req0_valid` input 1: requester 0 presents an operand pair.
- `req0_a`, `req0_b` input 8 each: requester 0 operands.
- `req0_ready` output 1: requester 0 operands accepted this cycle.
- `req1_valid`, `req1_a`, `req1_b`, `req1_ready`: same as requester 0, for requester 1.
- `res0_valid` output 1: sum for requester 0 is available.
- `res0_data` output 8: sum for requester 0.
- `res0_ready` input 1: requester 0 takes the sum.
- `res1_valid`, `res1_data`, `res1_ready`: same as requester 0, for requester 1.

## Operation
- FSM states:
  - IDLE: accepts a request.
  - BUSY: latched operands drive the adder; 1 cycle.
  - RESP: sum is registered and presented.
- IDLE behaviour:
  - `reqN_ready` = 1 only for the granted requester, and only when that requester's `reqN_valid` = 1. Combinational from valids and `last_grant`.
  - Grant rule:
    - Only one valid: that requester wins.
    - Both valid: the requester other than `last_grant` wins.
  - On handshake: latch `a`, `b` and `owner`; set `last_grant` = `owner`; go to BUSY.
- BUSY:
  - Register the `float_add` output into `sum_q`.
  - Go to RESP.
- RESP:
  - `res{owner}_valid` = 1 and `res{owner}_data` = `sum_q`.
  - The other result port has valid = 0 and data = 0.
  - When `res{owner}_ready` = 1, go to IDLE in the same edge.
- Both `reqN_ready` = 0 in BUSY and RESP. Requests arriving then wait; valid must stay asserted and operands held until ready.
- Arithmetic is exactly the `float_add` result on the latched operands. The scheduler does no rounding, saturation or rewriting.
- Requester-side `reqN_valid` drop without a handshake is legal and simply withdraws the request.

## Timing
- Reset values:
  - State IDLE.
  - `last_grant` = 1, so requester 0 wins the first contention.
  - `owner` = 0, `sum_q` = 0.
  - All `reqN_ready` and `resN_valid` = 0; `resN_data` = 0.
- Latency: operand handshake at edge T, BUSY in cycle T+1, `resN_valid` high from T+2.
- Minimum issue interval: 3 cycles (result accepted on the first RESP cycle, next grant in the following IDLE cycle).
- Result port backpressure:
  - `resN_valid`/`resN_data` stay stable while `resN_ready` = 0.
  - `resN_ready` asserted while `resN_valid` = 0 has no effect.
- Simultaneous `res_ready` and a new request in RESP: the new request is not accepted until the next IDLE cycle.
- `reset` in BUSY or RESP:
  - The in-flight operation is discarded.
  - Outputs take reset values at that edge; no result is delivered.
- `reset` dominates all other inputs in the same cycle.

## Structure
- Shared package `float_pkg`:
  - `FLOAT_W` = 8, `EXP_W` = 3, `MANT_W` = 5.
  - State encoding constants `S_IDLE`, `S_BUSY`, `S_RESP` (2-bit).
- Sub-modules:
  - One instance of `float_add` (aIn/bIn from the latched operands, result to `sum_q`).
  - Optionally a 2-way round-robin arbiter sub-module `rr_arb2` (inputs: two requests and `last_grant`; outputs: one-hot grant).
- Remaining logic: FSM, operand/owner registers, `last_grant` flop, output steering.

## Test plan
- Single request:
  - Stimulus: `req0` with a = 8'b001_01000, b = 8'b001_00100, `res0_ready` = 1.
  - Required response: `req0_ready` pulse at T, `res0_valid` at T+2 with `res0_data` = 8'b001_01100, `res1_valid` = 0 throughout.
- Mantissa overflow:
  - Stimulus: `req1` with a = b = 8'b001_10000.
  - Required response: `res1_data` = 8'b010_10000 at T+2.
- Contention from reset:
  - Stimulus: both valid in the same cycle.
  - Required response: `req0` served first, `req1` in the next IDLE cycle, then `req0` again if both are still valid (strict alternation over 4 grants).
- Backpressure:
  - Stimulus: `res0_ready` = 0 for 5 cycles.
  - Required response: `res0_valid`/`res0_data` stable for 5 cycles, `req1_ready` = 0 meanwhile; release → IDLE next edge.
- Reset mid-op:
  - Stimulus: assert `reset` in the BUSY cycle.
  - Required response: no `resN_valid` is produced, all outputs 0, next contention grants `req0`.
- Withdrawn request:
  - Stimulus: `req1_valid` pulses for one cycle while the block is in RESP.
  - Required response: no grant to `req1`, no result on port 1.

Source files
------------

// File: rtl/float_pkg.sv
// Shared widths and scheduler state encoding for the 8-bit float adder datapath.
package float_pkg;
    localparam int FLOAT_W = 8;
    localparam int EXP_W   = 3;
    localparam int MANT_W  = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;
endpackage

// File: rtl/float_add_scheduler_if.sv
// Operand and result handshake bundle for the two requesters of the shared adder.
interface float_add_scheduler_if;
    import float_pkg::*;

    logic               req0_valid, req0_ready;
    logic [FLOAT_W-1:0] req0_a, req0_b;
    logic               req1_valid, req1_ready;
    logic [FLOAT_W-1:0] req1_a, req1_b;
    logic               res0_valid, res0_ready;
    logic [FLOAT_W-1:0] res0_data;
    logic               res1_valid, res1_ready;
    logic [FLOAT_W-1:0] res1_data;

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        output res0_ready, res1_ready,
        input  req0_ready, req1_ready, res0_valid, res0_data, res1_valid, res1_data
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        input  res0_ready, res1_ready,
        output req0_ready, req1_ready, res0_valid, res0_data, res1_valid, res1_data
    );
endinterface

// File: rtl/float_add.sv
// Combinational 8-bit float add: align to the larger exponent (truncating), add,
// renormalise one place on mantissa carry; saturates to all-ones past the top exponent.
module float_add
    import float_pkg::*;
(
    input  logic [FLOAT_W-1:0] aIn,
    input  logic [FLOAT_W-1:0] bIn,
    output logic [FLOAT_W-1:0] result
);
    logic [EXP_W-1:0]  e_big, e_small, diff;
    logic [MANT_W-1:0] m_big, m_small, m_shift;
    logic [MANT_W:0]   m_sum;
    logic [EXP_W:0]    e_inc;

    always_comb begin
        if (aIn[FLOAT_W-1 -: EXP_W] >= bIn[FLOAT_W-1 -: EXP_W]) begin
            e_big   = aIn[FLOAT_W-1 -: EXP_W];
            m_big   = aIn[MANT_W-1:0];
            e_small = bIn[FLOAT_W-1 -: EXP_W];
            m_small = bIn[MANT_W-1:0];
        end else begin
            e_big   = bIn[FLOAT_W-1 -: EXP_W];
            m_big   = bIn[MANT_W-1:0];
            e_small = aIn[FLOAT_W-1 -: EXP_W];
            m_small = aIn[MANT_W-1:0];
        end
        diff    = e_big - e_small;
        m_shift = m_small >> diff;
        m_sum   = {1'b0, m_big} + {1'b0, m_shift};
        e_inc   = {1'b0, e_big} + {{EXP_W{1'b0}}, 1'b1};
        if (!m_sum[MANT_W])
            result = {e_big, m_sum[MANT_W-1:0]};
        else if (e_inc[EXP_W])
            result = {FLOAT_W{1'b1}};
        else
            result = {e_inc[EXP_W-1:0], m_sum[MANT_W:1]};
    end
endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request wins, contention goes to the one not granted last.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] gnt_o
);
    always_comb begin
        gnt_o = req_i;
        if (&req_i)
            gnt_o = last_grant_i ? 2'b01 : 2'b10;
    end
endmodule

// File: rtl/float_add_scheduler.sv
// Time-shares one float_add between two requesters: grant, settle one cycle, hold the
// registered sum on the winner's result port until it is taken.
module float_add_scheduler
    import float_pkg::*;
(
    input  logic clk,
    input  logic reset,
    float_add_scheduler_if.slave bus
);
    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               owner_q, owner_d;
    logic [FLOAT_W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [FLOAT_W-1:0] add_res;
    logic [1:0]         gnt;
    logic               accept, resp0, resp1;

    rr_arb2 u_arb (
        .req_i        ({bus.req1_valid, bus.req0_valid}),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt)
    );

    float_add u_add (
        .aIn    (a_q),
        .bIn    (b_q),
        .result (add_res)
    );

    // Ready is masked while reset is high, since that edge drops any accepted operands.
    assign accept         = (state_q == S_IDLE) && !reset;
    assign bus.req0_ready = accept && gnt[0];
    assign bus.req1_ready = accept && gnt[1];

    assign resp0          = (state_q == S_RESP) && !owner_q;
    assign resp1          = (state_q == S_RESP) &&  owner_q;
    assign bus.res0_valid = resp0;
    assign bus.res1_valid = resp1;
    assign bus.res0_data  = resp0 ? sum_q : '0;
    assign bus.res1_data  = resp1 ? sum_q : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sum_q        <= sum_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        a_d          = a_q;
        b_d          = b_q;
        sum_d        = sum_q;
        case (state_q)
            S_IDLE: begin
                if (|gnt) begin
                    owner_d      = gnt[1];
                    last_grant_d = gnt[1];
                    a_d          = gnt[1] ? bus.req1_a : bus.req0_a;
                    b_d          = gnt[1] ? bus.req1_b : bus.req0_b;
                    state_d      = S_BUSY;
                end
            end
            S_BUSY: begin
                sum_d   = add_res;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (owner_q ? bus.res1_ready : bus.res0_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule
